soric_wb_sram_responder: RTL and testbench

//  Wishbone classic slave (responder) in the SoRIC user project; serves management-SoC

---
 rtl/soric_wb_sram_responder_if.sv | 24 ++
 rtl/soric_wb_sram_responder.sv | 193 +++++++++++++++++++
 tb/tb_soric_wb_sram_responder.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/soric_wb_sram_responder_if.sv
// ---------------------------------------------------------------------------
// soric_wb_sram_responder_if
//   Wishbone classic bus bundle between the Caravel management SoC (master)
//   and the SoRIC SRAM responder (slave).
//   cyc, stb, we  : bus cycle, strobe, write-not-read
//   sel   [3:0]   : byte lane selects
//   adr   [31:0]  : byte address
//   dat_w [31:0]  : write data, master to slave
//   ack           : one-cycle transfer acknowledge, slave to master
//   dat_r [31:0]  : read data, slave to master, valid only while ack = 1
// ---------------------------------------------------------------------------
interface soric_wb_sram_responder_if;
  logic        cyc;
  logic        stb;
  logic        we;
  logic [3:0]  sel;
  logic [31:0] adr;
  logic [31:0] dat_w;
  logic        ack;
  logic [31:0] dat_r;

  modport master (output cyc, stb, we, sel, adr, dat_w, input ack, dat_r);
  modport slave  (input cyc, stb, we, sel, adr, dat_w, output ack, dat_r);
endinterface

// File: rtl/soric_wb_sram_responder.sv
// ---------------------------------------------------------------------------
// soric_wb_sram_responder
//   Wishbone classic slave that serves firmware reads/writes to a single-port
//   OpenRAM-style SRAM macro (port 0). All SRAM controls are registered and
//   only one transfer is outstanding at a time.
// Ports
//   wb_clk_i       : clock, all state on posedge
//   wb_rst_i       : asynchronous active-high reset
//   wbs            : Wishbone bus (slave modport)
//   sram_csb0_o    : SRAM chip select, active-low, one cycle per hit
//   sram_web0_o    : SRAM write enable, active-low
//   sram_wmask0_o  : SRAM byte write mask
//   sram_addr0_o   : SRAM word address
//   sram_din0_o    : SRAM write data
//   sram_dout0_i   : SRAM read data, valid READ_LAT cycles after select
// Configuration macro
//   SORIC_SRAM_STATS_EN : adds 16-bit read/write completion counters readable
//   at BASE_ADDR + 2^(ADDR_W+2); a write to that address clears them.
// ---------------------------------------------------------------------------
module soric_wb_sram_responder #(
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
  parameter int          ADDR_W    = 8,
  parameter int          READ_LAT  = 1
) (
  input  logic                 wb_clk_i,
  input  logic                 wb_rst_i,
  soric_wb_sram_responder_if.slave wbs,
  output logic                 sram_csb0_o,
  output logic                 sram_web0_o,
  output logic [3:0]           sram_wmask0_o,
  output logic [ADDR_W-1:0]    sram_addr0_o,
  output logic [31:0]          sram_din0_o,
  input  logic [31:0]          sram_dout0_i
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WR    = 3'd1,
    ST_RD    = 3'd2,
    ST_RWAIT = 3'd3,
    ST_MISS  = 3'd4,
    ST_ACK   = 3'd5
  } state_t;

  state_t      state_r;
  logic [1:0]  lat_cnt_r;
  logic        ack_r;
  logic [31:0] dat_r_r;
  logic        req_s;
  logic        hit_s;
  logic        unused_s;

  assign req_s = wbs.cyc & wbs.stb;
  assign hit_s = (wbs.adr[31:ADDR_W+2] == BASE_ADDR[31:ADDR_W+2]);
  // Byte offset within a word plays no part in addressing.
  assign unused_s = ^wbs.adr[1:0];

  assign wbs.ack   = ack_r;
  assign wbs.dat_r = dat_r_r;

`ifdef SORIC_SRAM_STATS_EN
  localparam logic [31:0] STATS_ADDR = BASE_ADDR + (32'd1 << (ADDR_W + 2));
  logic        stats_hit_s;
  logic        stats_rd_r;
  logic        stats_wr_r;
  logic [15:0] rd_cnt_r;
  logic [15:0] wr_cnt_r;
  assign stats_hit_s = (wbs.adr[31:2] == STATS_ADDR[31:2]);
`endif

  // Transfer FSM with registered SRAM controls and Wishbone response.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_r       <= ST_IDLE;
      lat_cnt_r     <= 2'd0;
      ack_r         <= 1'b0;
      dat_r_r       <= 32'd0;
      sram_csb0_o   <= 1'b1;
      sram_web0_o   <= 1'b1;
      sram_wmask0_o <= 4'd0;
      sram_addr0_o  <= '0;
      sram_din0_o   <= 32'd0;
`ifdef SORIC_SRAM_STATS_EN
      stats_rd_r    <= 1'b0;
      stats_wr_r    <= 1'b0;
      rd_cnt_r      <= 16'd0;
      wr_cnt_r      <= 16'd0;
`endif
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (req_s) begin
            if (hit_s) begin
              sram_csb0_o  <= 1'b0;
              sram_addr0_o <= wbs.adr[ADDR_W+1:2];
              if (wbs.we) begin
                sram_web0_o   <= 1'b0;
                sram_wmask0_o <= wbs.sel;
                sram_din0_o   <= wbs.dat_w;
                state_r       <= ST_WR;
              end else begin
                sram_web0_o   <= 1'b1;
                sram_wmask0_o <= 4'd0;
                state_r       <= ST_RD;
              end
            end else begin
`ifdef SORIC_SRAM_STATS_EN
              stats_rd_r <= stats_hit_s & ~wbs.we;
              stats_wr_r <= stats_hit_s & wbs.we;
`endif
              state_r <= ST_MISS;
            end
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_WR: begin
          // The SRAM has already sampled the write; an abort leaves it committed.
          sram_csb0_o   <= 1'b1;
          sram_web0_o   <= 1'b1;
          sram_wmask0_o <= 4'd0;
          if (!wbs.cyc) begin
            state_r <= ST_IDLE;
          end else begin
            ack_r   <= 1'b1;
`ifdef SORIC_SRAM_STATS_EN
            wr_cnt_r <= wr_cnt_r + 16'd1;
`endif
            state_r <= ST_ACK;
          end
        end
        ST_RD: begin
          sram_csb0_o <= 1'b1;
          if (!wbs.cyc) begin
            state_r <= ST_IDLE;
          end else begin
            // Counter reaches zero on the edge that ends the last latency cycle.
            lat_cnt_r <= 2'(READ_LAT - 1);
            state_r   <= ST_RWAIT;
          end
        end
        ST_RWAIT: begin
          if (!wbs.cyc) begin
            lat_cnt_r <= 2'd0;
            state_r   <= ST_IDLE;
          end else if (lat_cnt_r == 2'd0) begin
            dat_r_r <= sram_dout0_i;
            ack_r   <= 1'b1;
`ifdef SORIC_SRAM_STATS_EN
            rd_cnt_r <= rd_cnt_r + 16'd1;
`endif
            state_r <= ST_ACK;
          end else begin
            lat_cnt_r <= lat_cnt_r - 2'd1;
          end
        end
        ST_MISS: begin
          if (!wbs.cyc) begin
            state_r <= ST_IDLE;
          end else begin
            ack_r   <= 1'b1;
            dat_r_r <= 32'd0;
`ifdef SORIC_SRAM_STATS_EN
            if (stats_rd_r) begin
              dat_r_r <= {rd_cnt_r, wr_cnt_r};
            end else if (stats_wr_r) begin
              rd_cnt_r <= 16'd0;
              wr_cnt_r <= 16'd0;
            end else begin
              dat_r_r <= 32'd0;
            end
`endif
            state_r <= ST_ACK;
          end
        end
        ST_ACK: begin
          // Returning to IDLE here (not sampling) prevents double-acking a held strobe.
          ack_r   <= 1'b0;
          dat_r_r <= 32'd0;
          state_r <= ST_IDLE;
        end
        default: begin
          ack_r       <= 1'b0;
          dat_r_r     <= 32'd0;
          sram_csb0_o <= 1'b1;
          sram_web0_o <= 1'b1;
          state_r     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_soric_wb_sram_responder.sv
// ---------------------------------------------------------------------------
// tb_soric_wb_sram_responder
//   Self-checking bench: a driver issues Wishbone transfers and pushes the
//   expected response (data and ack cycle) into a queue; a negedge monitor pops
//   and compares on every ack. A behavioural SRAM (READ_LAT = 1) sits on port 0.
// ---------------------------------------------------------------------------
module tb_soric_wb_sram_responder;

  typedef struct {
    logic [31:0] data;
    int          cyc;
    string       name;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        csb0;
  logic        web0;
  logic [3:0]  wmask0;
  logic [7:0]  addr0;
  logic [31:0] din0;
  logic [31:0] dout0;
  logic [31:0] mem [0:255];

  int   vectors;
  int   miscompares;
  int   cyc_cnt;
  int   csb_lows;
  exp_t exp_q [$];

  soric_wb_sram_responder_if wbs ();

  soric_wb_sram_responder dut (
    .wb_clk_i      (clk),
    .wb_rst_i      (rst),
    .wbs           (wbs),
    .sram_csb0_o   (csb0),
    .sram_web0_o   (web0),
    .sram_wmask0_o (wmask0),
    .sram_addr0_o  (addr0),
    .sram_din0_o   (din0),
    .sram_dout0_i  (dout0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycle counter: value k holds during the cycle that follows edge k.
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  // Behavioural single-port SRAM: one-cycle read latency, byte-masked writes.
  always @(posedge clk) begin
    if (!csb0) begin
      if (!web0) begin
        for (int b = 0; b < 4; b++) begin
          if (wmask0[b]) mem[addr0][b*8 +: 8] <= din0[b*8 +: 8];
        end
      end else begin
        dout0 <= mem[addr0];
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Monitor: counts chip-select cycles and scores every ack against the queue.
  always @(negedge clk) begin
    exp_t e;
    if (csb0 === 1'b0) csb_lows++;
    if (wbs.ack === 1'b1) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL spurious_ack: got ack at cycle %0d, expected none", cyc_cnt);
      end else begin
        e = exp_q.pop_front();
        chk({e.name, "_data"}, wbs.dat_r, e.data);
        chk({e.name, "_ackcyc"}, 32'(cyc_cnt), 32'(e.cyc));
      end
    end
  end

  // One Wishbone transfer with pin checks in the SRAM cycle and ack scoring.
  task automatic wb_xfer(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                         input logic [3:0] sel, input logic [31:0] exp_dat, input string name);
    logic [31:0] base;
    logic        hit;
    logic        got;
    int          n;
    int          csb_before;
    exp_t        e;
    base = 32'h3000_0000;
    hit  = (adr[31:10] == base[31:10]);
    csb_before = csb_lows;
    @(posedge clk); #1;
    wbs.cyc = 1'b1; wbs.stb = 1'b1; wbs.we = we;
    wbs.adr = adr; wbs.dat_w = dat; wbs.sel = sel;
    @(posedge clk); #1;
    n = cyc_cnt;
    e.data = exp_dat;
    e.cyc  = n + ((hit && !we) ? 2 : 1);
    e.name = name;
    exp_q.push_back(e);
    if (hit) begin
      chk({name, "_csb"}, {31'd0, csb0}, 32'd0);
      chk({name, "_web"}, {31'd0, web0}, {31'd0, ~we});
      chk({name, "_addr"}, {24'd0, addr0}, {24'd0, adr[9:2]});
      chk({name, "_wmask"}, {28'd0, wmask0}, we ? {28'd0, sel} : 32'd0);
      if (we) chk({name, "_din"}, din0, dat);
    end
    got = 1'b0;
    for (int i = 0; i < 16 && !got; i++) begin
      @(negedge clk);
      if (wbs.ack === 1'b1) got = 1'b1;
    end
    if (!got) begin
      vectors++;
      miscompares++;
      $display("FAIL %s_timeout: got no ack, expected ack", name);
    end
    @(posedge clk); #1;
    wbs.cyc = 1'b0; wbs.stb = 1'b0; wbs.we = 1'b0;
    chk({name, "_dat_clear"}, wbs.dat_r, 32'd0);
    chk({name, "_csb_pulses"}, 32'(csb_lows - csb_before), hit ? 32'd1 : 32'd0);
  endtask

  initial begin
    logic [31:0] a;
    exp_t        e;
    int          n;
    int          csb_before;
    vectors = 0; miscompares = 0; cyc_cnt = 0; csb_lows = 0;
    dout0 = 32'd0;
    rst = 1'b1;
    wbs.cyc = 1'b0; wbs.stb = 1'b0; wbs.we = 1'b0;
    wbs.sel = 4'd0; wbs.adr = 32'd0; wbs.dat_w = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ack", {31'd0, wbs.ack}, 32'd0);
    chk("rst_dat", wbs.dat_r, 32'd0);
    chk("rst_csb", {31'd0, csb0}, 32'd1);
    chk("rst_web", {31'd0, web0}, 32'd1);
    chk("rst_wmask", {28'd0, wmask0}, 32'd0);
    chk("rst_addr", {24'd0, addr0}, 32'd0);
    chk("rst_din", din0, 32'd0);
    rst = 1'b0;

    // Statistics window (plain miss when the feature is compiled out).
    wb_xfer(1'b1, 32'h3000_0400, 32'h0, 4'hF, 32'h0, "st_clr0");
    wb_xfer(1'b1, 32'h3000_0040, 32'h1111_1111, 4'hF, 32'h0, "st_w0");
    wb_xfer(1'b1, 32'h3000_0044, 32'h2222_2222, 4'hF, 32'h0, "st_w1");
    wb_xfer(1'b1, 32'h3000_0048, 32'h3333_3333, 4'hF, 32'h0, "st_w2");
    wb_xfer(1'b0, 32'h3000_0040, 32'h0, 4'hF, 32'h1111_1111, "st_r0");
    wb_xfer(1'b0, 32'h3000_0044, 32'h0, 4'hF, 32'h2222_2222, "st_r1");
`ifdef SORIC_SRAM_STATS_EN
    wb_xfer(1'b0, 32'h3000_0400, 32'h0, 4'hF, 32'h0002_0003, "st_cnt");
`else
    wb_xfer(1'b0, 32'h3000_0400, 32'h0, 4'hF, 32'h0, "st_cnt");
`endif
    wb_xfer(1'b1, 32'h3000_0400, 32'hFFFF_FFFF, 4'hF, 32'h0, "st_clr");
    wb_xfer(1'b0, 32'h3000_0400, 32'h0, 4'hF, 32'h0, "st_cnt0");

    // Full word, byte lane and empty-mask writes.
    wb_xfer(1'b1, 32'h3000_0004, 32'hDEAD_BEEF, 4'hF, 32'h0, "wr_full");
    wb_xfer(1'b0, 32'h3000_0004, 32'h0, 4'hF, 32'hDEAD_BEEF, "rd_full");
    wb_xfer(1'b1, 32'h3000_0006, 32'h0000_AB00, 4'b0010, 32'h0, "wr_byte");
    wb_xfer(1'b0, 32'h3000_0004, 32'h0, 4'hF, 32'hDEAD_ABEF, "rd_byte");
    wb_xfer(1'b1, 32'h3000_0004, 32'hFFFF_FFFF, 4'b0000, 32'h0, "wr_nosel");
    wb_xfer(1'b0, 32'h3000_0004, 32'h0, 4'hF, 32'hDEAD_ABEF, "rd_nosel");

    // Misses outside the window.
    wb_xfer(1'b0, 32'h3100_0000, 32'h0, 4'hF, 32'h0, "miss_rd");
    wb_xfer(1'b1, 32'h2FFF_FFFC, 32'h5555_5555, 4'hF, 32'h0, "miss_wr");

    // Request held across ack: exactly two samples, two pulses, two acks.
    csb_before = csb_lows;
    @(posedge clk); #1;
    wbs.cyc = 1'b1; wbs.stb = 1'b1; wbs.we = 1'b1;
    wbs.adr = 32'h3000_0008; wbs.dat_w = 32'h1234_5678; wbs.sel = 4'hF;
    @(posedge clk); #1;
    n = cyc_cnt;
    e.data = 32'h0; e.cyc = n + 1; e.name = "hold_a"; exp_q.push_back(e);
    e.data = 32'h0; e.cyc = n + 4; e.name = "hold_b"; exp_q.push_back(e);
    while (cyc_cnt < n + 4) begin
      @(posedge clk); #1;
    end
    wbs.cyc = 1'b0; wbs.stb = 1'b0; wbs.we = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("hold_csb_pulses", 32'(csb_lows - csb_before), 32'd2);
    chk("hold_queue", 32'(exp_q.size()), 32'd0);
    wb_xfer(1'b0, 32'h3000_0008, 32'h0, 4'hF, 32'h1234_5678, "hold_rd");

    // Write aborted after the SRAM strobe: no ack, data still committed.
    @(posedge clk); #1;
    wbs.cyc = 1'b1; wbs.stb = 1'b1; wbs.we = 1'b1;
    wbs.adr = 32'h3000_000C; wbs.dat_w = 32'hCAFE_F00D; wbs.sel = 4'hF;
    @(posedge clk); #1;
    wbs.cyc = 1'b0; wbs.stb = 1'b0; wbs.we = 1'b0;
    repeat (4) @(posedge clk);
    wb_xfer(1'b0, 32'h3000_000C, 32'h0, 4'hF, 32'hCAFE_F00D, "abort_rd");

    // Asynchronous reset in the middle of a read.
    @(posedge clk); #1;
    wbs.cyc = 1'b1; wbs.stb = 1'b1; wbs.we = 1'b0;
    wbs.adr = 32'h3000_0004; wbs.sel = 4'hF;
    @(posedge clk); #1;
    chk("rstmid_csb_before", {31'd0, csb0}, 32'd0);
    #2 rst = 1'b1;
    #1;
    chk("rstmid_csb", {31'd0, csb0}, 32'd1);
    chk("rstmid_dat", wbs.dat_r, 32'd0);
    chk("rstmid_ack", {31'd0, wbs.ack}, 32'd0);
    wbs.cyc = 1'b0; wbs.stb = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (4) @(posedge clk);
    wb_xfer(1'b0, 32'h3000_0004, 32'h0, 4'hF, 32'hDEAD_ABEF, "rstmid_rd");

    // Whole array: 256 writes then 256 reads of address ^ pattern.
    for (int i = 0; i < 256; i++) begin
      a = 32'h3000_0000 + 32'(i) * 32'd4;
      wb_xfer(1'b1, a, a ^ 32'hA5A5_A5A5, 4'hF, 32'h0, "bulk_wr");
    end
    for (int i = 0; i < 256; i++) begin
      a = 32'h3000_0000 + 32'(i) * 32'd4;
      wb_xfer(1'b0, a, 32'h0, 4'hF, a ^ 32'hA5A5_A5A5, "bulk_rd");
    end

    repeat (4) @(posedge clk);
    #1;
    chk("final_queue", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
